leaf_stream_tx: RTL

//  Transmit side of the ap_vld/ap_ack stream handshake on a leaf, running in the user clock domain.

---
 rtl/leaf_stream_tx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/leaf_stream_tx.sv
// leaf_stream_tx: transmit side of the ap_vld/ap_ack stream handshake on a leaf.
// Buffers unpacked payload words in a circular RAM of DEPTH-1 entries followed by
// a single output register, so the total capacity is DEPTH words. Drained words
// are counted, and every FREESPACE_UPDATE_SIZE of them produce a one-cycle
// freespace_upd pulse so the interface can return credits upstream.
module leaf_stream_tx #(
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                          clk_user,
   input  logic                          reset,
   input  logic [PAYLOAD_BITS-1:0]       din,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          overflow,
   output logic [PAYLOAD_BITS-1:0]       dout,
   output logic                          vld,
   input  logic                          ack,
   output logic [NUM_BRAM_ADDR_BITS:0]   count,
   output logic                          freespace_upd
);

   localparam int DEPTH = 2 ** NUM_BRAM_ADDR_BITS;
   localparam int AW    = NUM_BRAM_ADDR_BITS;
   localparam int CW    = NUM_BRAM_ADDR_BITS + 1;

   // Pointers wrap at DEPTH-2 because the RAM holds one word fewer than DEPTH;
   // the output register supplies the last slot.
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 2);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] DRAIN_END = CW'(FREESPACE_UPDATE_SIZE - 1);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH-1];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           drain_cnt;

   logic xfer;
   logic wr_acc;
   logic ram_empty;
   logic out_free;
   logic load_ram;
   logic load_byp;
   logic ram_wr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   // count includes the output register, so the RAM is empty exactly when
   // every held word (0 or 1) sits in dout.
   assign xfer      = vld & ack;
   assign full      = (count == DEPTH_C);
   assign wr_acc    = wr_en & ~full;
   assign ram_empty = (count == CW'(vld));
   assign out_free  = xfer | ~vld;
   assign load_ram  = out_free & ~ram_empty;
   assign load_byp  = out_free & ram_empty & wr_acc;
   assign ram_wr    = wr_acc & ~load_byp;

   // Payload storage; contents are don't-care after reset since count gates reads.
   always_ff @(posedge clk_user) begin
      if (ram_wr)
         mem[wr_ptr] <= din;
   end

   // Output register: refill from RAM, bypass din into an empty block, or go idle.
   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
         vld  <= 1'b0;
         dout <= '0;
      end else if (load_ram) begin
         vld  <= 1'b1;
         dout <= mem[rd_ptr];
      end else if (load_byp) begin
         vld  <= 1'b1;
         dout <= din;
      end else if (out_free) begin
         vld  <= 1'b0;
      end
   end

   // Pointer advance and occupancy tracking.
   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (ram_wr)
            wr_ptr <= ptr_inc(wr_ptr);
         if (load_ram)
            rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(wr_acc) - CW'(xfer);
      end
   end

   // Sticky flag for any write attempted while full, even alongside a transfer.
   always_ff @(posedge clk_user or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (wr_en && full)
         overflow <= 1'b1;
   end

   // Drain counter: one freespace_upd pulse per FREESPACE_UPDATE_SIZE transfers.
   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
         drain_cnt     <= '0;
         freespace_upd <= 1'b0;
      end else begin
         freespace_upd <= 1'b0;
         if (xfer) begin
            if (drain_cnt == DRAIN_END) begin
               drain_cnt     <= '0;
               freespace_upd <= 1'b1;
            end else begin
               drain_cnt <= drain_cnt + 1'b1;
            end
         end
      end
   end

endmodule
